// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared types and helpers for the cache back-end arbiter.
// Optional beat-locking is enabled with IOB_CACHE_BE_ARB_LOCK_EN.
package iob_cache_be_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Index widths never collapse to zero bits, even for a single requester.
  function automatic int grant_w(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/iob_cache_rr_sel.sv
// Rotate-priority encoder: first set request at or above rr_ptr, wrapping.
module iob_cache_rr_sel
  import iob_cache_be_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int GRANT_W = grant_w(NREQ)
) (
  input  logic [NREQ-1:0]    req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic [GRANT_W-1:0] winner,
  output logic               any_req
);

  logic [NREQ-1:0]    rotated;
  logic [GRANT_W-1:0] offset;
  logic [GRANT_W:0]   sum;

  assign rotated = NREQ'({req, req} >> rr_ptr);
  assign any_req = |req;

  // Lowest set bit of the rotated vector is the distance from rr_ptr.
  always_comb begin
    offset = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = GRANT_W'(i);
    end
  end

  assign sum    = {1'b0, rr_ptr} + {1'b0, offset};
  assign winner = (sum >= (GRANT_W + 1)'(NREQ)) ?
                  GRANT_W'(sum - (GRANT_W + 1)'(NREQ)) : sum[GRANT_W-1:0];

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Round-robin arbiter sharing one IOb native back-end port between NREQ caches.
// Define IOB_CACHE_BE_ARB_LOCK_EN to keep up to MAX_LOCK consecutive beats atomic.
module iob_cache_be_arbiter
  import iob_cache_be_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*ADDR_W-1:0]   addr_i,
  input  logic [NREQ*DATA_W-1:0]   wdata_i,
  input  logic [NREQ*DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [NREQ-1:0]          ack_o,
  output logic                     be_req_o,
  output logic [ADDR_W-1:0]        be_addr_o,
  output logic [DATA_W-1:0]        be_wdata_o,
  output logic [DATA_W/8-1:0]      be_wstrb_o,
  input  logic [DATA_W-1:0]        be_rdata_i,
  input  logic                     be_ack_i
);

  localparam int GRANT_W = grant_w(NREQ);
  localparam int STRB_W  = DATA_W / 8;

  arb_state_t         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] winner;
  logic [GRANT_W-1:0] next_ptr;
  logic               any_req;
  logic               gnt_req;

`ifdef IOB_CACHE_BE_ARB_LOCK_EN
  localparam int LOCK_W = grant_w(MAX_LOCK);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
`endif

  iob_cache_rr_sel #(
    .NREQ    (NREQ),
    .GRANT_W (GRANT_W)
  ) u_rr_sel (
    .req     (req_i),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign gnt_req  = req_i[grant_q];
  assign next_ptr = (grant_q == GRANT_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef IOB_CACHE_BE_ARB_LOCK_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lock_cnt_q <= '0;
    else          lock_cnt_q <= lock_cnt_d;
  end
`endif

  // Back-end outputs are only driven while BUSY so a reset clears them at once.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    be_req_o   = 1'b0;
    be_addr_o  = '0;
    be_wdata_o = '0;
    be_wstrb_o = '0;
    ack_o      = '0;
    rdata_o    = '0;
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        be_req_o   = gnt_req;
        be_addr_o  = addr_i[grant_q*ADDR_W +: ADDR_W];
        be_wdata_o = wdata_i[grant_q*DATA_W +: DATA_W];
        be_wstrb_o = wstrb_i[grant_q*STRB_W +: STRB_W];
        if (!gnt_req) begin
          state_d = IDLE;
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
          // A drop after at least one locked beat is a normal release.
          if (lock_cnt_q != '0) rr_ptr_d = next_ptr;
          lock_cnt_d = '0;
`endif
        end else if (be_ack_i) begin
          ack_o[grant_q] = 1'b1;
          rdata_o        = be_rdata_i;
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
          if (lock_cnt_q == LOCK_LAST) begin
            state_d    = IDLE;
            rr_ptr_d   = next_ptr;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
`else
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Directed self-checking bench for iob_cache_be_arbiter (NREQ=2, MAX_LOCK=4).
// Beat ordering expectations follow IOB_CACHE_BE_ARB_LOCK_EN when defined.
module tb_iob_cache_be_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [31:0] rdata;
  logic [1:0]  ack;
  logic        be_req;
  logic [31:0] be_addr;
  logic [31:0] be_wdata;
  logic [3:0]  be_wstrb;
  logic [31:0] be_rdata;
  logic        be_ack;

  int assert_count = 0;
  int fail_count   = 0;

  iob_cache_be_arbiter #(
    .NREQ     (2),
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_LOCK (4)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .wstrb_i    (wstrb),
    .rdata_o    (rdata),
    .ack_o      (ack),
    .be_req_o   (be_req),
    .be_addr_o  (be_addr),
    .be_wdata_o (be_wdata),
    .be_wstrb_o (be_wstrb),
    .be_rdata_i (be_rdata),
    .be_ack_i   (be_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic a);
    req    = r;
    be_ack = a;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int rem0;
    int rem1;
    int acks;
    logic [15:0] order;
    logic [15:0] exp_order;

    rst_n    = 1'b0;
    req      = 2'b00;
    be_ack   = 1'b0;
    addr     = {32'h0000_2004, 32'h0000_0100};
    wdata    = {32'hA5A5_A5A5, 32'h1111_1111};
    wstrb    = {4'b0011, 4'b0000};
    be_rdata = 32'hDEAD_BEEF;

    #12;
    checkOutput("rst_be_req", 32'(be_req), 32'h0);
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_be_addr", be_addr, 32'h0);
    checkOutput("rst_be_wstrb", 32'(be_wstrb), 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);

    // Single read from requester 0
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(2'b01, 1'b0);
    checkOutput("rd_arb_cycle", 32'(be_req), 32'h0);
    nextCycle();
    checkOutput("rd_be_req", 32'(be_req), 32'h1);
    checkOutput("rd_be_addr", be_addr, 32'h100);
    checkOutput("rd_be_wstrb", 32'(be_wstrb), 32'h0);
    checkOutput("rd_wait_ack", 32'(ack), 32'h0);
    nextCycle();
    checkOutput("rd_wait_ack2", 32'(ack), 32'h0);
    nextCycle();
    applyStimulus(2'b01, 1'b1);
    checkOutput("rd_ack", 32'(ack), 32'h1);
    checkOutput("rd_rdata", rdata, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(2'b00, 1'b0);
    checkOutput("rd_done_be_req", 32'(be_req), 32'h0);
    checkOutput("rd_done_ack", 32'(ack), 32'h0);

    // Back-end ack while idle is ignored
    applyStimulus(2'b00, 1'b1);
    checkOutput("idle_ack", 32'(ack), 32'h0);
    checkOutput("idle_rdata", rdata, 32'h0);

    // Contention with an always-acking back-end; rr_ptr is 1 here
    applyStimulus(2'b11, 1'b1);
    checkOutput("cont_idle_ack", 32'(ack), 32'h0);
    for (int c = 0; c < 8; c++) begin
      nextCycle();
      if (c % 2 == 1)        checkOutput("cont_ack", 32'(ack), 32'h0);
      else if (c % 4 == 0)   checkOutput("cont_ack", 32'(ack), 32'h2);
      else                   checkOutput("cont_ack", 32'(ack), 32'h1);
      checkOutput("cont_be_req", 32'(be_req), (c % 2 == 0) ? 32'h1 : 32'h0);
    end
    applyStimulus(2'b00, 1'b0);

    // Write from requester 1 while requester 0 also waits
    applyStimulus(2'b11, 1'b0);
    nextCycle();
    checkOutput("wr_be_req", 32'(be_req), 32'h1);
    checkOutput("wr_be_addr", be_addr, 32'h2004);
    checkOutput("wr_be_wdata", be_wdata, 32'hA5A5_A5A5);
    checkOutput("wr_be_wstrb", 32'(be_wstrb), 32'h3);
    applyStimulus(2'b11, 1'b1);
    checkOutput("wr_ack", 32'(ack), 32'h2);
    nextCycle();
    applyStimulus(2'b01, 1'b0);
    checkOutput("wr_then_idle", 32'(be_req), 32'h0);
    nextCycle();
    checkOutput("wait_served_addr", be_addr, 32'h100);

    // Asynchronous reset in the middle of a transaction
    applyStimulus(2'b01, 1'b1);
    checkOutput("pre_rst_ack", 32'(ack), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_be_req", 32'(be_req), 32'h0);
    checkOutput("async_rst_ack", 32'(ack), 32'h0);
    checkOutput("async_rst_addr", be_addr, 32'h0);
    applyStimulus(2'b11, 1'b0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(2'b11, 1'b0);
    checkOutput("post_rst_idle", 32'(be_req), 32'h0);
    nextCycle();
    checkOutput("post_rst_be_req", 32'(be_req), 32'h1);
    checkOutput("post_rst_winner", be_addr, 32'h100);
    applyStimulus(2'b11, 1'b1);
    checkOutput("post_rst_ack", 32'(ack), 32'h1);
    nextCycle();
    applyStimulus(2'b10, 1'b0);
    nextCycle();
    applyStimulus(2'b10, 1'b1);
    checkOutput("post_rst_ack1", 32'(ack), 32'h2);
    nextCycle();

    // Requester 0 drops its request before the back-end acks
    applyStimulus(2'b11, 1'b0);
    nextCycle();
    checkOutput("viol_busy", 32'(be_req), 32'h1);
    applyStimulus(2'b10, 1'b0);
    checkOutput("viol_be_req", 32'(be_req), 32'h0);
    checkOutput("viol_ack", 32'(ack), 32'h0);
    nextCycle();
    applyStimulus(2'b11, 1'b0);
    checkOutput("viol_idle", 32'(be_req), 32'h0);
    nextCycle();
    checkOutput("viol_ptr_kept", be_addr, 32'h100);
    applyStimulus(2'b11, 1'b1);
    checkOutput("viol_retry_ack", 32'(ack), 32'h1);
    nextCycle();
    applyStimulus(2'b10, 1'b0);
    nextCycle();
    checkOutput("viol_next_addr", be_addr, 32'h2004);
    applyStimulus(2'b10, 1'b1);
    checkOutput("viol_next_ack", 32'(ack), 32'h2);
    nextCycle();
    applyStimulus(2'b00, 1'b0);

    // Eight beats from each requester against an always-acking back-end
    rem0  = 8;
    rem1  = 8;
    acks  = 0;
    order = '0;
    for (int cyc = 0; cyc < 80 && acks < 16; cyc++) begin
      applyStimulus({rem1 > 0, rem0 > 0}, 1'b1);
      if (ack[0] && acks < 16) begin
        order[acks] = 1'b0;
        acks++;
        rem0--;
      end
      if (ack[1] && acks < 16) begin
        order[acks] = 1'b1;
        acks++;
        rem1--;
      end
      nextCycle();
    end
    applyStimulus(2'b00, 1'b0);
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
    exp_order = 16'hF0F0;
`else
    exp_order = 16'hAAAA;
`endif
    checkOutput("beat_count", 32'(acks), 32'd16);
    checkOutput("beat_order", 32'(order), 32'(exp_order));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
